// File: rtl/fetch_bp_pkg.sv
// Shared definitions for the fetch branch predictor update path.
package fetch_bp_pkg;

  // Two-bit PHT pattern encodings.
  localparam logic [1:0] STRONG_TAKEN     = 2'b01;
  localparam logic [1:0] WEAK_TAKEN       = 2'b00;
  localparam logic [1:0] WEAK_NOT_TAKEN   = 2'b10;
  localparam logic [1:0] STRONG_NOT_TAKEN = 2'b11;

  // Fall-through fetch address is the branch plus its delay slot.
  localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

  // One resolved branch waiting to update the fetch predictor.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  pattern;
    logic        btb_wr;
  } bp_entry_t;

  localparam int ENTRY_W = $bits(bp_entry_t);

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous in-order FIFO with registered pointers and occupancy count.
// The head entry is presented combinationally on rdata; storage is cleared
// on reset so the head reads as zero while empty after reset.
module bp_update_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Occupancy next-state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  // Storage, pointers (wrap naturally at DEPTH) and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolve_update.sv
// Execute-stage branch resolution: detects mispredicts, issues a registered
// redirect, queues resolved branches to feed one PHT (and optional BTB)
// update per cycle to fetch, and keeps branch/mispredict counters.
//
// Handshake: a branch transfers on a rising edge where res_valid && res_ready.
// res_ready comes only from the registered occupancy, so a pop in the same
// cycle never lets a full queue accept; upstream must hold its data while
// res_ready is low.
module branch_resolve_update
  import fetch_bp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic [1:0]  res_pattern,
  input  logic        res_pred_taken,
  input  logic        res_pred_target_valid,
  input  logic [31:0] res_pred_target,
  input  logic        update_hold,
  output logic        pht_update_en,
  output logic [31:0] pht_update_pc,
  output logic [1:0]  pht_update_oldpattern,
  output logic        pht_update_taken,
  output logic        btb_update_en,
  output logic [31:0] btb_update_pc,
  output logic [31:0] btb_update_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  bp_entry_t push_entry, head_entry;
  logic      fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

  logic        accept, target_wrong, mispredict, pop;
  logic [31:0] redirect_pc_d;

  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q, perf_branches_q, perf_mispredicts_q;

  // Classify the offered branch and build the queue entry.
  always_comb begin
    accept        = res_valid && res_ready;
    target_wrong  = !res_pred_target_valid || (res_pred_target != res_target);
    mispredict    = (res_pred_taken != res_taken) ||
                    (res_taken && res_pred_taken && target_wrong);
    redirect_pc_d = res_taken ? res_target : (res_pc + DELAY_SLOT_OFFSET);
    push_entry.pc      = res_pc;
    push_entry.taken   = res_taken;
    push_entry.target  = res_target;
    push_entry.pattern = res_pattern;
    push_entry.btb_wr  = res_taken && target_wrong;
    pop                = !fifo_empty && !update_hold;
  end

  bp_update_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign res_ready             = !fifo_full;
  assign pht_update_en         = pop;
  assign pht_update_pc         = head_entry.pc;
  assign pht_update_oldpattern = head_entry.pattern;
  assign pht_update_taken      = head_entry.taken;
  assign btb_update_en         = pop && head_entry.btb_wr;
  assign btb_update_pc         = head_entry.pc;
  assign btb_update_target     = head_entry.target;

  // One-cycle redirect pulse after an accepted mispredict; counters wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      redirect_valid_q <= accept && mispredict;
      if (accept && mispredict) redirect_pc_q <= redirect_pc_d;
      if (accept) perf_branches_q <= perf_branches_q + 32'd1;
      if (accept && mispredict) perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_update.sv
// Directed bench for branch_resolve_update with a queue-based reference model.
module tb_branch_resolve_update;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        res_valid, res_ready;
  logic [31:0] res_pc, res_target, res_pred_target;
  logic        res_taken, res_pred_taken, res_pred_target_valid;
  logic [1:0]  res_pattern;
  logic        update_hold;
  logic        pht_update_en, pht_update_taken, btb_update_en, redirect_valid;
  logic [31:0] pht_update_pc, btb_update_pc, btb_update_target, redirect_pc;
  logic [1:0]  pht_update_oldpattern;
  logic [31:0] perf_branches, perf_mispredicts;

  branch_resolve_update #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .res_valid             (res_valid),
    .res_ready             (res_ready),
    .res_pc                (res_pc),
    .res_taken             (res_taken),
    .res_target            (res_target),
    .res_pattern           (res_pattern),
    .res_pred_taken        (res_pred_taken),
    .res_pred_target_valid (res_pred_target_valid),
    .res_pred_target       (res_pred_target),
    .update_hold           (update_hold),
    .pht_update_en         (pht_update_en),
    .pht_update_pc         (pht_update_pc),
    .pht_update_oldpattern (pht_update_oldpattern),
    .pht_update_taken      (pht_update_taken),
    .btb_update_en         (btb_update_en),
    .btb_update_pc         (btb_update_pc),
    .btb_update_target     (btb_update_target),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .perf_branches         (perf_branches),
    .perf_mispredicts      (perf_mispredicts)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each expected update is {pc, taken, target, pattern, btb_write}.
  logic [67:0] exp_q[$];
  logic        m_rv;
  logic [31:0] m_rpc, m_br, m_mp;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    bit          acc, pop_now, wrong_dir, wrong_tgt, mis, bw;
    if (reset) begin
      exp_q.delete();
      m_rv  = 1'b0;
      m_rpc = 32'd0;
      m_br  = 32'd0;
      m_mp  = 32'd0;
      model_live = 1'b1;
    end else if (model_live) begin
      acc       = res_valid && (exp_q.size() < DEPTH);
      pop_now   = (exp_q.size() > 0) && !update_hold;
      wrong_dir = (res_pred_taken != res_taken);
      wrong_tgt = res_taken && (!res_pred_target_valid || res_pred_target != res_target);
      mis       = wrong_dir || wrong_tgt;
      bw        = wrong_tgt;
      if (pop_now) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({res_pc, res_taken, res_target, res_pattern, bw});
      m_rv = acc && mis;
      if (acc && mis) m_rpc = res_taken ? res_target : res_pc + 32'd8;
      if (acc) m_br = m_br + 32'd1;
      if (acc && mis) m_mp = m_mp + 32'd1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    bit          h;
    logic [31:0] e_pc, e_tg;
    logic        e_tk, e_bw;
    logic [1:0]  e_pt;
    if (model_live) begin
      h = (exp_q.size() > 0) && !update_hold;
      check("m_res_ready", 32'(res_ready), 32'(exp_q.size() < DEPTH));
      check("m_pht_en", 32'(pht_update_en), 32'(h));
      if (h) begin
        {e_pc, e_tk, e_tg, e_pt, e_bw} = exp_q[0];
        check("m_pht_pc", pht_update_pc, e_pc);
        check("m_pht_pattern", 32'(pht_update_oldpattern), 32'(e_pt));
        check("m_pht_taken", 32'(pht_update_taken), 32'(e_tk));
        check("m_btb_en", 32'(btb_update_en), 32'(e_bw));
        if (e_bw) begin
          check("m_btb_pc", btb_update_pc, e_pc);
          check("m_btb_target", btb_update_target, e_tg);
        end
      end else begin
        check("m_btb_en_idle", 32'(btb_update_en), 32'd0);
      end
      check("m_redirect_valid", 32'(redirect_valid), 32'(m_rv));
      if (m_rv) check("m_redirect_pc", redirect_pc, m_rpc);
      check("m_perf_branches", perf_branches, m_br);
      check("m_perf_mispredicts", perf_mispredicts, m_mp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_branch(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                            input logic [1:0] pat, input logic pt, input logic ptv,
                            input logic [31:0] ptgt);
    res_pc                = pc;
    res_taken             = t;
    res_target            = tgt;
    res_pattern           = pat;
    res_pred_taken        = pt;
    res_pred_target_valid = ptv;
    res_pred_target       = ptgt;
  endtask

  // Offer one branch for a single edge (caller ensures res_ready is high).
  task automatic send(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                      input logic [1:0] pat, input logic pt, input logic ptv,
                      input logic [31:0] ptgt);
    set_branch(pc, t, tgt, pat, pt, ptv, ptgt);
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit rdy, fifth_acc;
    reset       = 1'b1;
    res_valid   = 1'b0;
    update_hold = 1'b0;
    set_branch(32'd0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(res_ready), 32'd1);
    check("rst_pht_en", 32'(pht_update_en), 32'd0);
    check("rst_btb_en", 32'(btb_update_en), 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_pht_pc", pht_update_pc, 32'd0);
    check("rst_branches", perf_branches, 32'd0);
    check("rst_mispredicts", perf_mispredicts, 32'd0);

    // Correct not-taken prediction
    send(32'h1000, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("nt_redirect", 32'(redirect_valid), 32'd0);
    check("nt_pht_en", 32'(pht_update_en), 32'd1);
    check("nt_pht_pc", pht_update_pc, 32'h1000);
    check("nt_pattern", 32'(pht_update_oldpattern), 32'd3);
    check("nt_taken", 32'(pht_update_taken), 32'd0);
    check("nt_btb_en", 32'(btb_update_en), 32'd0);
    check("nt_mispredicts", perf_mispredicts, 32'd0);
    check("nt_branches", perf_branches, 32'd1);

    // Direction mispredict, BTB miss
    send(32'h2000, 1'b1, 32'h3000, 2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("dir_redirect", 32'(redirect_valid), 32'd1);
    check("dir_redirect_pc", redirect_pc, 32'h3000);
    check("dir_pht_en", 32'(pht_update_en), 32'd1);
    check("dir_btb_en", 32'(btb_update_en), 32'd1);
    check("dir_btb_pc", btb_update_pc, 32'h2000);
    check("dir_btb_target", btb_update_target, 32'h3000);
    check("dir_mispredicts", perf_mispredicts, 32'd1);
    @(negedge clk);
    check("dir_redirect_pulse_end", 32'(redirect_valid), 32'd0);

    // Target mispredict
    send(32'h2400, 1'b1, 32'h5000, 2'b01, 1'b1, 1'b1, 32'h4000);
    @(negedge clk);
    check("tgt_redirect", 32'(redirect_valid), 32'd1);
    check("tgt_redirect_pc", redirect_pc, 32'h5000);
    check("tgt_btb_en", 32'(btb_update_en), 32'd1);
    check("tgt_btb_target", btb_update_target, 32'h5000);
    check("tgt_mispredicts", perf_mispredicts, 32'd2);

    // Predicted taken, actually not taken, fall-through wraps
    send(32'hFFFF_FFFC, 1'b0, 32'h80, 2'b01, 1'b1, 1'b1, 32'h80);
    @(negedge clk);
    check("wrap_redirect", 32'(redirect_valid), 32'd1);
    check("wrap_redirect_pc", redirect_pc, 32'h0000_0004);
    check("wrap_btb_en", 32'(btb_update_en), 32'd0);
    check("wrap_mispredicts", perf_mispredicts, 32'd3);

    // Correctly predicted taken with matching BTB target
    send(32'h3000, 1'b1, 32'h3400, 2'b00, 1'b1, 1'b1, 32'h3400);
    @(negedge clk);
    check("hit_redirect", 32'(redirect_valid), 32'd0);
    check("hit_btb_en", 32'(btb_update_en), 32'd0);
    check("hit_pht_taken", 32'(pht_update_taken), 32'd1);
    check("hit_branches", perf_branches, 32'd5);

    // Back-to-back mispredicts, each with its own redirect target
    send(32'h5000, 1'b1, 32'h6000, 2'b10, 1'b0, 1'b0, 32'h0);
    send(32'h5100, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'h7000);
    @(negedge clk);
    check("b2b_redirect", 32'(redirect_valid), 32'd1);
    check("b2b_redirect_pc", redirect_pc, 32'h5108);
    check("b2b_mispredicts", perf_mispredicts, 32'd5);
    repeat (3) @(negedge clk);

    // Hold with five offered branches: four fill the queue, fifth waits
    @(posedge clk); #1;
    update_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_branch(32'h100 + 32'(i * 4), 1'b0, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
      res_valid = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("hold_full_ready", 32'(res_ready), 32'd0);
    check("hold_pht_en", 32'(pht_update_en), 32'd0);
    check("hold_branches", perf_branches, 32'd11);
    @(posedge clk); #1;
    update_hold = 1'b0;
    fifth_acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_pht_en", 32'(pht_update_en), 32'd1);
      check("drain_pht_pc", pht_update_pc, 32'h100 + 32'(i * 4));
      rdy = res_ready;
      @(posedge clk); #1;
      if (rdy && res_valid) begin
        res_valid = 1'b0;
        fifth_acc = 1'b1;
      end
    end
    res_valid = 1'b0;
    check("fifth_accepted", 32'(fifth_acc), 32'd1);
    @(negedge clk);
    check("fifth_pht_pc", pht_update_pc, 32'h110);
    check("fifth_branches", perf_branches, 32'd12);
    repeat (2) @(negedge clk);

    // Reset with three queued entries
    @(posedge clk); #1;
    update_hold = 1'b1;
    send(32'h8000, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, 32'h0);
    send(32'h8004, 1'b1, 32'h9000, 2'b01, 1'b1, 1'b0, 32'h0);
    send(32'h8008, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("pre_rst_ready", 32'(res_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    update_hold = 1'b0;
    @(negedge clk);
    check("mid_rst_pht_en", 32'(pht_update_en), 32'd0);
    check("mid_rst_btb_en", 32'(btb_update_en), 32'd0);
    check("mid_rst_ready", 32'(res_ready), 32'd1);
    check("mid_rst_branches", perf_branches, 32'd0);
    check("mid_rst_mispredicts", perf_mispredicts, 32'd0);
    check("mid_rst_redirect", 32'(redirect_valid), 32'd0);
    @(negedge clk);
    check("mid_rst_pht_en_later", 32'(pht_update_en), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
